// File: rtl/round_robin_scheduler_pkg.sv
// Shared constants for the output-queue scheduler.
// Mode encodings and index-width helpers.
package round_robin_scheduler_pkg;

   localparam logic [1:0] MODE_RR       = 2'd0;
   localparam logic [1:0] MODE_WEIGHTED = 2'd1;
   localparam logic [1:0] MODE_TABLE    = 2'd2;
   localparam logic [1:0] MODE_PRIO     = 2'd3;

   localparam int unsigned DEF_MAX_WEIGHT = 64;

   // Index width that stays >= 1 for single-entry counts.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_next_nonempty.sv
// Circular first-one search starting at (and including) start.
// Lowest circular offset from start wins.
module rr_next_nonempty
   import round_robin_scheduler_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is kept.
   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, start} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/round_robin_scheduler.sv
// Multi-mode output-queue scheduler: plain RR, weighted burst,
// table-driven and strict priority, with registered grants.
module round_robin_scheduler
   import round_robin_scheduler_pkg::*;
#(
   parameter  int unsigned QUEUE_QUANTITY = 4,
   parameter  int unsigned MAX_WEIGHT     = DEF_MAX_WEIGHT,
   parameter  int unsigned WEIGHT_BITS    = $clog2(MAX_WEIGHT),
   parameter  int unsigned TABLE_SIZE     = 8,
   localparam int unsigned QW             = idx_w(QUEUE_QUANTITY),
   localparam int unsigned TW             = idx_w(TABLE_SIZE)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enb,
   input  logic [1:0]                        mode,
   input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos,
   input  logic [TABLE_SIZE*WEIGHT_BITS-1:0] pesosArbitraje,
   input  logic [TABLE_SIZE*QW-1:0]          selecciones,
   input  logic [QUEUE_QUANTITY-1:0]         buf_empty,
   input  logic                              dst_ready,
   output logic [QW-1:0]                     selector,
   output logic                              selector_enb
);

   logic [1:0]               mode_q, mode_d;
   logic [QW-1:0]            ptr_q, ptr_d, ptr_inc;
   logic [WEIGHT_BITS:0]     cnt_q, cnt_d;
   logic [TW-1:0]            tidx_q, tidx_d, tidx_inc;
   logic [QW-1:0]            sel_d;
   logic                     en_d;

   logic [QUEUE_QUANTITY-1:0] nonempty, eligible, srch_req;
   logic                      srch_found;
   logic [QW-1:0]             srch_idx;
   logic [WEIGHT_BITS-1:0]    w_ptr, tab_b;
   logic [QW-1:0]             tab_s;
   logic                      tab_ne;
   logic [QW-1:0]             prio_idx;

   assign nonempty = ~buf_empty;
   assign ptr_inc  = (ptr_q == QW'(QUEUE_QUANTITY - 1)) ? '0 : ptr_q + QW'(1);
   assign tidx_inc = (tidx_q == TW'(TABLE_SIZE - 1)) ? '0 : tidx_q + TW'(1);
   assign w_ptr    = pesos[ptr_q*WEIGHT_BITS +: WEIGHT_BITS];
   assign tab_s    = selecciones[tidx_q*QW +: QW];
   assign tab_b    = pesosArbitraje[tidx_q*WEIGHT_BITS +: WEIGHT_BITS];
   assign srch_req = (mode_q == MODE_WEIGHTED) ? eligible : nonempty;

   // Queues that may start a new weighted burst (non-empty, weight set).
   always_comb begin
      eligible = '0;
      for (int q = 0; q < QUEUE_QUANTITY; q++)
         eligible[q] = nonempty[q] &&
                       (pesos[q*WEIGHT_BITS +: WEIGHT_BITS] != '0);
   end

   // Table entry readiness; out-of-range queue indices count as empty.
   always_comb begin
      tab_ne = 1'b0;
      if ({1'b0, tab_s} < (QW+1)'(QUEUE_QUANTITY))
         tab_ne = nonempty[tab_s];
   end

   // Lowest-index non-empty queue for strict priority.
   always_comb begin
      prio_idx = '0;
      for (int q = QUEUE_QUANTITY - 1; q >= 0; q--)
         if (nonempty[q]) prio_idx = QW'(q);
   end

   rr_next_nonempty #(
      .N     (QUEUE_QUANTITY)
   ) u_search (
      .req   (srch_req),
      .start (ptr_inc),
      .found (srch_found),
      .idx   (srch_idx)
   );

   // Next-grant decision for the active mode.
   always_comb begin
      mode_d = mode_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      tidx_d = tidx_q;
      sel_d  = selector;
      en_d   = 1'b0;
      if (enb && dst_ready) begin
         if (mode != mode_q) begin
            mode_d = mode;
            cnt_d  = '0;
            tidx_d = '0;
         end else begin
            unique case (mode_q)
               MODE_RR: begin
                  if (srch_found) begin
                     en_d  = 1'b1;
                     sel_d = srch_idx;
                     ptr_d = srch_idx;
                  end
               end
               MODE_WEIGHTED: begin
                  if (nonempty[ptr_q] && (w_ptr != '0) &&
                      (cnt_q < {1'b0, w_ptr})) begin
                     en_d  = 1'b1;
                     sel_d = ptr_q;
                     cnt_d = cnt_q + (WEIGHT_BITS+1)'(1);
                  end else if (srch_found) begin
                     en_d  = 1'b1;
                     sel_d = srch_idx;
                     ptr_d = srch_idx;
                     cnt_d = (WEIGHT_BITS+1)'(1);
                  end else begin
                     cnt_d = '0;
                  end
               end
               MODE_TABLE: begin
                  if (&buf_empty) begin
                     cnt_d = '0;
                  end else if (tab_ne && (tab_b != '0) &&
                               (cnt_q < {1'b0, tab_b})) begin
                     en_d  = 1'b1;
                     sel_d = tab_s;
                     cnt_d = cnt_q + (WEIGHT_BITS+1)'(1);
                  end else begin
                     tidx_d = tidx_inc;
                     cnt_d  = '0;
                  end
               end
               MODE_PRIO: begin
                  if (|nonempty) begin
                     en_d  = 1'b1;
                     sel_d = prio_idx;
                  end
               end
            endcase
         end
      end
   end

   // Scheduler state and registered grant outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q       <= MODE_RR;
         ptr_q        <= QW'(QUEUE_QUANTITY - 1);
         cnt_q        <= '0;
         tidx_q       <= '0;
         selector     <= '0;
         selector_enb <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         tidx_q       <= tidx_d;
         selector     <= sel_d;
         selector_enb <= en_d;
      end
   end

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Bench for round_robin_scheduler: directed vector table,
// async reset sequence, then random stimulus against a model.
module tb_round_robin_scheduler;

   localparam int Q  = 4;
   localparam int WB = 6;
   localparam int TS = 3;
   localparam int QW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              enb;
   logic [1:0]        mode;
   logic [Q*WB-1:0]   pesos;
   logic [TS*WB-1:0]  pesos_arb;
   logic [TS*QW-1:0]  selecciones;
   logic [Q-1:0]      buf_empty;
   logic              dst_ready;
   logic [QW-1:0]     selector;
   logic              selector_enb;

   always #5 clk = ~clk;

   round_robin_scheduler #(
      .QUEUE_QUANTITY (Q),
      .MAX_WEIGHT     (64),
      .TABLE_SIZE     (TS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enb            (enb),
      .mode           (mode),
      .pesos          (pesos),
      .pesosArbitraje (pesos_arb),
      .selecciones    (selecciones),
      .buf_empty      (buf_empty),
      .dst_ready      (dst_ready),
      .selector       (selector),
      .selector_enb   (selector_enb)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm,
                      input logic [1:0] as, input logic ae,
                      input logic [1:0] es, input logic ee);
      checks++;
      if (as !== es || ae !== ee) begin
         errors++;
         $display("FAIL %s: got sel=%0d en=%0b, want sel=%0d en=%0b",
                  nm, as, ae, es, ee);
      end
   endtask

   typedef struct {
      logic [1:0] md;
      logic [3:0] be;
      logic       rdy;
      logic       en;
      logic [1:0] xs;
      logic       xe;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] md, input logic [3:0] be,
                      input logic rdy, input logic en,
                      input logic [1:0] xs, input logic xe);
      vec_t r;
      r.md = md; r.be = be; r.rdy = rdy; r.en = en;
      r.xs = xs; r.xe = xe;
      vecs.push_back(r);
   endtask

   // Reference model: scheduler state as plain integers.
   int m_ptr, m_cnt, m_t, m_mq, m_sel;
   bit m_en;

   function automatic int wt(input int q);
      return int'(pesos[q*WB +: WB]);
   endfunction

   function automatic bit has(input int q);
      return !buf_empty[q];
   endfunction

   task automatic model_reset();
      m_ptr = Q - 1; m_cnt = 0; m_t = 0; m_mq = 0;
      m_sel = 0; m_en = 0;
   endtask

   task automatic model_step();
      int q, s, b;
      m_en = 0;
      if (!enb || !dst_ready) return;
      if (int'(mode) != m_mq) begin
         m_mq = int'(mode); m_cnt = 0; m_t = 0;
         return;
      end
      case (m_mq)
         0: begin
            for (int k = 1; k <= Q; k++) begin
               q = (m_ptr + k) % Q;
               if (has(q)) begin
                  m_sel = q; m_en = 1; m_ptr = q;
                  break;
               end
            end
         end
         1: begin
            if (has(m_ptr) && wt(m_ptr) > 0 && m_cnt < wt(m_ptr)) begin
               m_sel = m_ptr; m_en = 1; m_cnt++;
            end else begin
               m_cnt = 0;
               for (int k = 1; k <= Q; k++) begin
                  q = (m_ptr + k) % Q;
                  if (has(q) && wt(q) > 0) begin
                     m_sel = q; m_en = 1; m_ptr = q; m_cnt = 1;
                     break;
                  end
               end
            end
         end
         2: begin
            if (buf_empty == '1) begin
               m_cnt = 0;
            end else begin
               s = int'(selecciones[m_t*QW +: QW]);
               b = int'(pesos_arb[m_t*WB +: WB]);
               if (s < Q && has(s) && b > 0 && m_cnt < b) begin
                  m_sel = s; m_en = 1; m_cnt++;
               end else begin
                  m_t = (m_t + 1) % TS; m_cnt = 0;
               end
            end
         end
         default: begin
            for (int k = 0; k < Q; k++) begin
               if (has(k)) begin
                  m_sel = k; m_en = 1;
                  break;
               end
            end
         end
      endcase
   endtask

   initial begin
      rst         = 1'b0;
      enb         = 1'b1;
      dst_ready   = 1'b1;
      mode        = 2'd0;
      buf_empty   = '1;
      pesos       = {6'd1, 6'd0, 6'd3, 6'd2};
      pesos_arb   = {6'd0, 6'd1, 6'd2};
      selecciones = {2'd1, 2'd2, 2'd0};

      repeat (2) @(posedge clk);
      #1 chk("reset", selector, selector_enb, 2'd0, 1'b0);

      // plain RR, enable freeze, skipping, all empty
      add(0, 4'b0000, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 1);
      add(0, 4'b0000, 1, 1, 2, 1);
      add(0, 4'b0000, 1, 1, 3, 1);
      add(0, 4'b0000, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 0, 0);
      add(0, 4'b0101, 1, 1, 1, 1);
      add(0, 4'b0101, 1, 1, 3, 1);
      add(0, 4'b0101, 1, 1, 1, 1);
      add(0, 4'b0101, 1, 1, 3, 1);
      add(0, 4'b1111, 1, 1, 3, 0);
      // weighted: change bubble then 3,0,0,1,1,1,3,0,0
      add(1, 4'b0000, 1, 1, 3, 0);
      add(1, 4'b0000, 1, 1, 3, 1);
      add(1, 4'b0000, 1, 1, 0, 1);
      add(1, 4'b0000, 1, 1, 0, 1);
      add(1, 4'b0000, 1, 1, 1, 1);
      add(1, 4'b0000, 1, 1, 1, 1);
      add(1, 4'b0000, 1, 1, 1, 1);
      add(1, 4'b0000, 1, 1, 3, 1);
      add(1, 4'b0000, 1, 1, 0, 1);
      add(1, 4'b0000, 1, 1, 0, 1);
      // table: entries (q0,b2) (q2,b1) (q1,b0), wraps mod 3
      add(2, 4'b0000, 1, 1, 0, 0);
      add(2, 4'b0000, 1, 1, 0, 1);
      add(2, 4'b0000, 1, 1, 0, 1);
      add(2, 4'b0000, 1, 1, 0, 0);
      add(2, 4'b0000, 1, 1, 2, 1);
      add(2, 4'b0000, 1, 1, 2, 0);
      add(2, 4'b0000, 1, 1, 2, 0);
      add(2, 4'b0000, 1, 1, 0, 1);
      add(2, 4'b0000, 1, 1, 0, 1);
      // strict priority with a two-cycle stall
      add(3, 4'b0011, 1, 1, 0, 0);
      add(3, 4'b0011, 1, 1, 2, 1);
      add(3, 4'b0011, 1, 1, 2, 1);
      add(3, 4'b0011, 0, 1, 2, 0);
      add(3, 4'b0011, 0, 1, 2, 0);
      add(3, 4'b0011, 1, 1, 2, 1);
      // weighted burst on q1, interrupted by reset below
      add(1, 4'b0001, 1, 1, 2, 0);
      add(1, 4'b0001, 1, 1, 1, 1);
      add(1, 4'b0001, 1, 1, 1, 1);

      @(negedge clk);
      rst = 1'b1;
      foreach (vecs[i]) begin
         mode      = vecs[i].md;
         buf_empty = vecs[i].be;
         dst_ready = vecs[i].rdy;
         enb       = vecs[i].en;
         @(posedge clk);
         #1 chk($sformatf("vec%0d", i), selector, selector_enb,
                vecs[i].xs, vecs[i].xe);
      end

      // asynchronous reset mid-burst
      #3 rst = 1'b0;
      #1 chk("rst_async", selector, selector_enb, 2'd0, 1'b0);
      @(posedge clk);
      #1 chk("rst_hold", selector, selector_enb, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("post_rst_bubble", selector, selector_enb, 2'd0, 1'b0);
      @(posedge clk);
      #1 chk("post_rst_grant", selector, selector_enb, 2'd3, 1'b1);

      // randomized run against the model
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
         buf_empty = 4'($urandom & $urandom);
         dst_ready = ($urandom_range(0, 7) != 0);
         enb       = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 49) == 0)
            for (int q = 0; q < Q; q++)
               pesos[q*WB +: WB] = 6'($urandom_range(0, 4));
         if ($urandom_range(0, 49) == 0)
            for (int t = 0; t < TS; t++) begin
               pesos_arb[t*WB +: WB]   = 6'($urandom_range(0, 3));
               selecciones[t*QW +: QW] = 2'($urandom);
            end
         @(posedge clk);
         model_step();
         #1 chk($sformatf("rand%0d", i), selector, selector_enb,
                2'(m_sel), m_en);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
